dvi_tmds_encoder: RTL

DVI_TMDS_ENCODER -- requirements
Module: dvi_tmds_encoder

---
 rtl/dvi_tmds_encoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder for 4-bit-per-channel video.
// Two register stages: stage 1 holds the transition-minimised word q_m with
// aligned DE/syncs; stage 2 applies DC balancing (or control symbols during
// blanking) and registers the 10-bit symbols for an external serializer.
module dvi_tmds_encoder (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic [3:0] red_i,
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       dv_de_i,
  output logic [9:0] tmds_red_o,
  output logic [9:0] tmds_green_o,
  output logic [9:0] tmds_blue_o
);

  // Channel indices; blue carries the syncs during blanking.
  localparam int unsigned NCH     = 3;
  localparam int unsigned CH_BLUE = 0;
  localparam int unsigned CH_GRN  = 1;
  localparam int unsigned CH_RED  = 2;

  // Control symbols indexed by {C1,C0}.
  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [4:0] cnt;
  } enc_t;

  // Expand a 4-bit colour to 8 bits and form the transition-minimised q_m.
  function automatic logic [8:0] qm_encode(input logic [3:0] c);
    logic [7:0] d;
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    d  = {c, c};
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1 = n1 + {3'b000, d[i]};
    end
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC-balance one q_m word against the running disparity.
  // bal = N1 - N0 = 2*N1 - 8; 5-bit wraparound is exact because every true
  // result lies within -16..15.
  function automatic enc_t dc_balance(input logic [8:0] qm,
                                      input logic signed [4:0] cnt);
    logic [3:0]        n1;
    logic signed [4:0] bal;
    enc_t              r;
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1 = n1 + {3'b000, qm[i]};
    end
    bal = $signed({n1, 1'b0} - 5'd8);
    if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
      r.sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      r.cnt = qm[8] ? (cnt + bal) : (cnt - bal);
    end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                 ((cnt < 5'sd0) && (bal < 5'sd0))) begin
      r.sym = {1'b1, qm[8], ~qm[7:0]};
      r.cnt = cnt - bal + (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      r.sym = {1'b0, qm[8], qm[7:0]};
      r.cnt = cnt + bal - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return r;
  endfunction

  // Control symbol lookup for the sync-carrying channel.
  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    logic [9:0] s;
    case ({c1, c0})
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  logic [3:0]        colour  [NCH];
  logic [8:0]        qm_s1   [NCH];
  logic              de_s1;
  logic              hs_s1;
  logic              vs_s1;
  enc_t              enc_v   [NCH];
  logic [9:0]        sym_nxt [NCH];
  logic signed [4:0] cnt_nxt [NCH];
  logic [9:0]        sym_r   [NCH];
  logic signed [4:0] cnt_r   [NCH];

  // Map the colour inputs onto channel slots.
  always_comb begin
    colour[CH_BLUE] = blue_i;
    colour[CH_GRN]  = green_i;
    colour[CH_RED]  = red_i;
  end

  // Stage 1: register q_m per channel with DE and syncs alongside.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        qm_s1[ch] <= '0;
      end
      de_s1 <= 1'b0;
      hs_s1 <= 1'b0;
      vs_s1 <= 1'b0;
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        qm_s1[ch] <= qm_encode(colour[ch]);
      end
      de_s1 <= dv_de_i;
      hs_s1 <= hsync_i;
      vs_s1 <= vsync_i;
    end
  end

  // Stage 2 next state: balanced data symbol, or control symbol with the
  // disparity cleared so the next active pixel starts from zero.
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      enc_v[ch] = dc_balance(qm_s1[ch], cnt_r[ch]);
      if (de_s1) begin
        sym_nxt[ch] = enc_v[ch].sym;
        cnt_nxt[ch] = enc_v[ch].cnt;
      end else begin
        sym_nxt[ch] = (ch == CH_BLUE) ? ctrl_sym(vs_s1, hs_s1) : CTRL_00;
        cnt_nxt[ch] = '0;
      end
    end
  end

  // Stage 2: register output symbols and running disparity.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        sym_r[ch] <= CTRL_00;
        cnt_r[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        sym_r[ch] <= sym_nxt[ch];
        cnt_r[ch] <= cnt_nxt[ch];
      end
    end
  end

  assign tmds_blue_o  = sym_r[CH_BLUE];
  assign tmds_green_o = sym_r[CH_GRN];
  assign tmds_red_o   = sym_r[CH_RED];

  // The balancing algorithm keeps |cnt| <= 10; anything larger is a bug.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_cnt_chk
    cnt_in_range: assert property (@(posedge clk) disable iff (!reset_n_i)
      (cnt_r[ch] >= -5'sd10) && (cnt_r[ch] <= 5'sd10));
  end

endmodule
